alu_sequencer: RTL

Instruction sequencer and 4-entry register file. It feeds the clocked ArithmeticLogicUnit and consumes its result. It accepts one 10-bit instruction per handshake and decodes the opcode into the ALU's nine one-hot control lines. It then drives the ALU operands from the register file and writes the registered ALU result back to the destination register. It sits between the instruction source (program ROM or bench) and the ALU.

---
 rtl/alu_pkg.sv | 69 ++++++
 rtl/alu_regfile.sv | 44 ++++
 rtl/alu_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, ALU control
// bit indices (also used by the ALU and the bench), FSM state encoding and
// small decode helpers.
package alu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LSR = 4'h3;
    localparam logic [3:0] OP_LSH = 4'h4;
    localparam logic [3:0] OP_RSH = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_INV = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;

    localparam int CTRL_ADD = 0;
    localparam int CTRL_SUB = 1;
    localparam int CTRL_LSR = 2;
    localparam int CTRL_LSH = 3;
    localparam int CTRL_RSH = 4;
    localparam int CTRL_AND = 5;
    localparam int CTRL_OR  = 6;
    localparam int CTRL_XOR = 7;
    localparam int CTRL_INV = 8;
    localparam int CTRL_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // One-hot ALU control for an opcode; zero for NOP, LDI and illegal codes.
    function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [3:0] op);
        logic [CTRL_W-1:0] ctrl;
        ctrl = '0;
        case (op)
            OP_ADD:  ctrl[CTRL_ADD] = 1'b1;
            OP_SUB:  ctrl[CTRL_SUB] = 1'b1;
            OP_LSR:  ctrl[CTRL_LSR] = 1'b1;
            OP_LSH:  ctrl[CTRL_LSH] = 1'b1;
            OP_RSH:  ctrl[CTRL_RSH] = 1'b1;
            OP_AND:  ctrl[CTRL_AND] = 1'b1;
            OP_OR:   ctrl[CTRL_OR]  = 1'b1;
            OP_XOR:  ctrl[CTRL_XOR] = 1'b1;
            OP_INV:  ctrl[CTRL_INV] = 1'b1;
            default: ctrl = '0;
        endcase
        return ctrl;
    endfunction

    // Opcodes whose ALU result is written back (LSR only loads the ALU shifter).
    function automatic logic writes_alu_result(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) ||
               ((op >= OP_LSH) && (op <= OP_INV));
    endfunction

    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_LDI;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU sequencer: 2^ADDR_W x DATA_W flops with async
// reset, two combinational operand read ports, one debug read port and one
// synchronous write port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Register storage: cleared on reset, one write per clock.
    // NOTE: this array is reset on purpose; that forces flops rather than a RAM
    // macro, which is fine at this size and gives a defined power-up state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the clocked ALU. Accepts one 10-bit instruction
// per handshake, walks IDLE -> EXEC -> WB, drives one-hot ALU controls and
// operands from the register file, and writes the registered ALU result back.
// Optional build macro ALU_SEQ_OVF_TRAP_EN: an ADD/SUB overflow suppresses the
// writeback and parks the FSM in HALT until reset.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [9:0]        instr,
    output logic [8:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow,
    output logic              done,
    output logic              illegal,
    output logic              ovf_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

`ifdef ALU_SEQ_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t state, state_next;

    logic [3:0]        ir_op;
    logic [ADDR_W-1:0] ir_rd;
    logic [ADDR_W-1:0] ir_rs;
    logic [3:0]        ir_imm;

    logic              ovf_hit;
    logic              trap;
    logic              we;
    logic [DATA_W-1:0] wdata;

    assign ovf_hit = (state == ST_WB) && is_arith(ir_op) && alu_overflow;
    assign trap    = TRAP_EN && ovf_hit;
    assign we      = (state == ST_WB) &&
                     ((writes_alu_result(ir_op) && !trap) || (ir_op == OP_LDI));
    assign wdata   = (ir_op == OP_LDI) ? DATA_W'(ir_imm) : alu_out;

    // FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state and decoded outputs for the current state.
    // NOTE: every output gets a default first so no path leaves a value held,
    // which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        alu_ctrl    = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                alu_ctrl   = decode_ctrl(ir_op);
                state_next = ST_WB;
            end
            ST_WB: begin
                done       = 1'b1;
                illegal    = is_illegal(ir_op);
                state_next = trap ? ST_HALT : ST_IDLE;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // Instruction register, loaded on the accept handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_op  <= OP_NOP;
            ir_rd  <= '0;
            ir_rs  <= '0;
            ir_imm <= '0;
        end else if ((state == ST_IDLE) && instr_valid) begin
            ir_op  <= instr[9:6];
            ir_rd  <= instr[4 +: ADDR_W];
            ir_rs  <= instr[ADDR_W-1:0];
            ir_imm <= instr[3:0];
        end
    end

    // Sticky overflow from ADD/SUB, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ovf_flag <= 1'b0;
        else if (ovf_hit) ovf_flag <= 1'b1;
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (ir_rd),
        .wdata    (wdata),
        .raddr1   (ir_rd),
        .raddr2   (ir_rs),
        .rdata1   (alu_in1),
        .rdata2   (alu_in2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule
